// File: rtl/up_interface_gen.sv
// uP handshake slave: receives a command packet over a 4-phase handshake
// bus, performs one register-bank access and returns a data+status reply.
// The pad tristate is owned by the top level through uP_data_oe.
module up_interface_gen #(
  parameter int BUS_WIDTH      = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int STATUS_WIDTH   = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    async_uP_start,
  input  logic                    async_uP_handshake_1,
  input  logic                    async_uP_RW,
  input  logic [BUS_WIDTH-1:0]    uP_data_in,
  output logic [BUS_WIDTH-1:0]    uP_data_out,
  output logic                    uP_data_oe,
  output logic                    uP_ack,
  output logic                    uP_handshake_2,
  output logic [BUS_WIDTH-1:0]    reg_cmd,
  output logic [ADDR_WIDTH-1:0]   reg_address,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic                    reg_req,
  input  logic                    reg_ack,
  input  logic [DATA_WIDTH-1:0]   reg_rdata,
  input  logic [STATUS_WIDTH-1:0] reg_status,
  output logic                    timeout_flag
);

  localparam int NW       = DATA_WIDTH / BUS_WIDTH;
  localparam int NS       = STATUS_WIDTH / BUS_WIDTH;
  localparam int RX_WORDS = 2 + NW;
  localparam int TX_WORDS = NW + NS;
  localparam int CNT_MAX  = (RX_WORDS > TX_WORDS) ? RX_WORDS : TX_WORDS;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_WORDS - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_WORDS - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_WAIT_H1,
    S_RX_WAIT_H1_LOW,
    S_EXEC,
    S_TX_WAIT_H1,
    S_TX_WAIT_H1_LOW,
    S_DONE
  } state_t;

  // Synchroniser chains (index 1 is the usable synchronised value)
  logic [1:0] start_sync_q, start_sync_d;
  logic [1:0] h1_sync_q, h1_sync_d;
  logic [1:0] rw_sync_q, rw_sync_d;
  logic       start_prev_q, start_prev_d;
  logic       start_evt, h1_s, rw_s;

  // Control state
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]         tcnt_q, tcnt_d;
  logic                    hs2_q, hs2_d;
  logic                    req_q, req_d;
  logic                    ack_q, ack_d;
  logic                    flag_q, flag_d;
  logic [BUS_WIDTH-1:0]    dout_q, dout_d;

  // Packet slots
  logic [BUS_WIDTH-1:0]    cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [STATUS_WIDTH-1:0] status_q, status_d;

  logic [TX_WORDS*BUS_WIDTH-1:0] reply_vec;
  logic [BUS_WIDTH-1:0]          reply_word;
  logic                          timed;
  logic                          cmd_valid;

  // Next values of the synchroniser chains and start edge detector
  always_comb begin
    start_sync_d = {start_sync_q[0], async_uP_start};
    h1_sync_d    = {h1_sync_q[0], async_uP_handshake_1};
    rw_sync_d    = {rw_sync_q[0], async_uP_RW};
    start_prev_d = start_sync_q[1];
  end

  // Synchroniser registers
  always_ff @(posedge clk) begin
    if (reset) begin
      start_sync_q <= '0;
      h1_sync_q    <= '0;
      rw_sync_q    <= '0;
      start_prev_q <= 1'b0;
    end else begin
      start_sync_q <= start_sync_d;
      h1_sync_q    <= h1_sync_d;
      rw_sync_q    <= rw_sync_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign start_evt = start_sync_q[1] & ~start_prev_q;
  assign h1_s      = h1_sync_q[1];
  assign rw_s      = rw_sync_q[1];

  assign reply_vec = {status_q, rdata_q};
  assign cmd_valid = (cmd_q == BUS_WIDTH'(0)) || (cmd_q == BUS_WIDTH'(1));

  // Select the reply word addressed by the word counter
  always_comb begin
    reply_word = '0;
    if (int'(cnt_q) < TX_WORDS) begin
      reply_word = reply_vec[BUS_WIDTH*int'(cnt_q) +: BUS_WIDTH];
    end
  end

  // Next-state, slot capture, handshake and timeout logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    hs2_d    = hs2_q;
    req_d    = req_q;
    ack_d    = ack_q;
    flag_d   = flag_q;
    dout_d   = dout_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;

    timed = (state_q == S_RX_WAIT_H1) || (state_q == S_RX_WAIT_H1_LOW) ||
            (state_q == S_EXEC) || (state_q == S_TX_WAIT_H1) ||
            (state_q == S_TX_WAIT_H1_LOW);

    case (state_q)
      S_IDLE, S_DONE: begin
        // only a start event (handled below) leaves these states
      end

      S_RX_WAIT_H1: begin
        if (h1_s && rw_s) begin
          if (cnt_q == CNT_W'(0)) begin
            cmd_d = uP_data_in;
          end else if (cnt_q == CNT_W'(1)) begin
            addr_d = uP_data_in[ADDR_WIDTH-1:0];
          end else begin
            wdata_d[BUS_WIDTH*(int'(cnt_q)-2) +: BUS_WIDTH] = uP_data_in;
          end
          hs2_d   = 1'b1;
          state_d = S_RX_WAIT_H1_LOW;
        end
      end

      S_RX_WAIT_H1_LOW: begin
        if (!h1_s) begin
          hs2_d   = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == RX_LAST) ? S_EXEC : S_RX_WAIT_H1;
        end
      end

      S_EXEC: begin
        if (cmd_valid) begin
          // bank ack only counts once our request is actually visible
          if (req_q && reg_ack) begin
            rdata_d  = reg_rdata;
            status_d = reg_status;
            status_d[STATUS_WIDTH-2] = reg_status[STATUS_WIDTH-2] | flag_q;
            req_d    = 1'b0;
            cnt_d    = '0;
            state_d  = S_TX_WAIT_H1;
          end else begin
            req_d = 1'b1;
          end
        end else begin
          rdata_d  = '0;
          status_d = '0;
          status_d[STATUS_WIDTH-1] = 1'b1;
          status_d[STATUS_WIDTH-2] = flag_q;
          cnt_d    = '0;
          state_d  = S_TX_WAIT_H1;
        end
      end

      S_TX_WAIT_H1: begin
        // data is registered on the first cycle here, strobe follows a
        // cycle later; the uP strobe is only honoured once ours is up
        dout_d = reply_word;
        if (hs2_q && h1_s) begin
          hs2_d   = 1'b0;
          state_d = S_TX_WAIT_H1_LOW;
        end else if (tcnt_q != '0) begin
          hs2_d = 1'b1;
        end
      end

      S_TX_WAIT_H1_LOW: begin
        if (!h1_s) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == TX_LAST) begin
            state_d = S_DONE;
            ack_d   = 1'b1;
            // a set flag here was necessarily reported in this reply
            flag_d  = 1'b0;
          end else begin
            state_d = S_TX_WAIT_H1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (timed && (tcnt_q == TO_LAST)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      req_d   = 1'b0;
      hs2_d   = 1'b0;
      ack_d   = 1'b0;
      flag_d  = 1'b1;
    end

    // a start event restarts reception from any state
    if (start_evt) begin
      state_d = S_RX_WAIT_H1;
      cnt_d   = '0;
      req_d   = 1'b0;
      hs2_d   = 1'b0;
      ack_d   = 1'b0;
    end

    if (!timed || start_evt || (state_d != state_q)) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  // Control and visible-output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      hs2_q   <= 1'b0;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      flag_q  <= 1'b0;
      dout_q  <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      hs2_q   <= hs2_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      flag_q  <= flag_d;
      dout_q  <= dout_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Reply payload registers; always written in EXEC before being sent
  always_ff @(posedge clk) begin
    rdata_q  <= rdata_d;
    status_q <= status_d;
  end

  // Drive the pad only while replying and the uP has released the bus
  assign uP_data_oe = ((state_q == S_TX_WAIT_H1) || (state_q == S_TX_WAIT_H1_LOW)) && !rw_s;

  assign uP_data_out    = dout_q;
  assign uP_ack         = ack_q;
  assign uP_handshake_2 = hs2_q;
  assign reg_cmd        = cmd_q;
  assign reg_address    = addr_q;
  assign reg_wdata      = wdata_q;
  assign reg_req        = req_q;
  assign timeout_flag   = flag_q;

endmodule

// File: tb/tb_up_interface_gen.sv
// Bench for up_interface_gen: an 8-bit bus instance and a 16-bit bus
// instance share the uP-side pins; the bench talks to one at a time.
module tb_up_interface_gen;

  logic        clk;
  logic        reset;
  logic        start, h1, rw;
  logic [15:0] data_in;
  logic [31:0] bank_rd, bank_st;

  logic [7:0]  a_dout, a_cmd, a_addr;
  logic        a_oe, a_ack, a_hs2, a_req, a_rack, a_flag;
  logic [31:0] a_wdata;
  logic [15:0] b_dout, b_cmd;
  logic [7:0]  b_addr;
  logic        b_oe, b_ack, b_hs2, b_req, b_rack, b_flag;
  logic [31:0] b_wdata;

  up_interface_gen #(.BUS_WIDTH(8), .DATA_WIDTH(32), .STATUS_WIDTH(32),
                     .ADDR_WIDTH(8), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .async_uP_start(start),
    .async_uP_handshake_1(h1), .async_uP_RW(rw), .uP_data_in(data_in[7:0]),
    .uP_data_out(a_dout), .uP_data_oe(a_oe), .uP_ack(a_ack),
    .uP_handshake_2(a_hs2), .reg_cmd(a_cmd), .reg_address(a_addr),
    .reg_wdata(a_wdata), .reg_req(a_req), .reg_ack(a_rack),
    .reg_rdata(bank_rd), .reg_status(bank_st), .timeout_flag(a_flag));

  up_interface_gen #(.BUS_WIDTH(16), .DATA_WIDTH(32), .STATUS_WIDTH(32),
                     .ADDR_WIDTH(8), .TIMEOUT_CYCLES(64)) dut16 (
    .clk(clk), .reset(reset), .async_uP_start(start),
    .async_uP_handshake_1(h1), .async_uP_RW(rw), .uP_data_in(data_in),
    .uP_data_out(b_dout), .uP_data_oe(b_oe), .uP_ack(b_ack),
    .uP_handshake_2(b_hs2), .reg_cmd(b_cmd), .reg_address(b_addr),
    .reg_wdata(b_wdata), .reg_req(b_req), .reg_ack(b_rack),
    .reg_rdata(bank_rd), .reg_status(bank_st), .timeout_flag(b_flag));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank models: ack a few cycles after a request, log requests
  int a_lat, b_lat, a_nreq, b_nreq;
  logic a_req_d1, b_req_d1;
  logic [15:0] a_cap_cmd, b_cap_cmd;
  logic [7:0]  a_cap_addr, b_cap_addr;
  logic [31:0] a_cap_wd, b_cap_wd;
  initial begin
    a_lat = 0; b_lat = 0; a_nreq = 0; b_nreq = 0;
    a_req_d1 = 1'b0; b_req_d1 = 1'b0; a_rack = 1'b0; b_rack = 1'b0;
  end
  always @(posedge clk) begin
    a_rack <= 1'b0;
    if (a_req && !a_rack) begin
      if (a_lat == 2) begin a_rack <= 1'b1; a_lat <= 0; end
      else a_lat <= a_lat + 1;
    end else a_lat <= 0;
    a_req_d1 <= a_req;
    if (a_req && !a_req_d1) begin
      a_nreq <= a_nreq + 1; a_cap_cmd <= {8'h00, a_cmd};
      a_cap_addr <= a_addr; a_cap_wd <= a_wdata;
    end
    b_rack <= 1'b0;
    if (b_req && !b_rack) begin
      if (b_lat == 2) begin b_rack <= 1'b1; b_lat <= 0; end
      else b_lat <= b_lat + 1;
    end else b_lat <= 0;
    b_req_d1 <= b_req;
    if (b_req && !b_req_d1) begin
      b_nreq <= b_nreq + 1; b_cap_cmd <= b_cmd;
      b_cap_addr <= b_addr; b_cap_wd <= b_wdata;
    end
  end

  // View of whichever instance the bench is currently talking to
  logic        sel;
  int          bw;
  logic [15:0] cur_dout, cur_cmd, cur_cap_cmd;
  logic [7:0]  cur_addr, cur_cap_addr;
  logic [31:0] cur_wdata, cur_cap_wd;
  logic        cur_oe, cur_ack, cur_hs2, cur_req, cur_flag;
  int          cur_nreq;
  assign cur_dout     = sel ? b_dout : {8'h00, a_dout};
  assign cur_cmd      = sel ? b_cmd : {8'h00, a_cmd};
  assign cur_addr     = sel ? b_addr : a_addr;
  assign cur_wdata    = sel ? b_wdata : a_wdata;
  assign cur_oe       = sel ? b_oe : a_oe;
  assign cur_ack      = sel ? b_ack : a_ack;
  assign cur_hs2      = sel ? b_hs2 : a_hs2;
  assign cur_req      = sel ? b_req : a_req;
  assign cur_flag     = sel ? b_flag : a_flag;
  assign cur_nreq     = sel ? b_nreq : a_nreq;
  assign cur_cap_cmd  = sel ? b_cap_cmd : a_cap_cmd;
  assign cur_cap_addr = sel ? b_cap_addr : a_cap_addr;
  assign cur_cap_wd   = sel ? b_cap_wd : a_cap_wd;

  // The block must never drive while the uP drives
  int oe_viol;
  initial oe_viol = 0;
  always @(posedge clk) if (rw === 1'b1 && cur_oe === 1'b1) oe_viol <= oe_viol + 1;

  int checks, errors;
  bit model_flag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return cur_hs2;
      1:       return cur_ack;
      default: return cur_flag;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input logic v, input int max);
    int n;
    n = 0;
    while (pick(which) !== v && n < max) begin @(negedge clk); n++; end
    chk(tag, 64'(pick(which)), 64'(v));
  endtask

  // Reference reply: data then status, bad command and timeout bits per rules
  function automatic logic [63:0] exp_reply(input int cmd, input logic [31:0] rd,
                                            input logic [31:0] st, input bit flag);
    logic [31:0] d, s;
    if (cmd == 0 || cmd == 1) begin d = rd; s = st; end
    else begin d = 32'h0; s = 32'h8000_0000; end
    if (flag) s = s | 32'h4000_0000;
    return {s, d};
  endfunction

  task automatic start_pulse();
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w);
    data_in = w; h1 = 1'b1;
    wait_for("rx_hs2_high", 0, 1'b1, 400);
    h1 = 1'b0;
    wait_for("rx_hs2_low", 0, 1'b0, 400);
  endtask

  task automatic recv_word(output logic [15:0] w);
    wait_for("tx_hs2_high", 0, 1'b1, 400);
    w = cur_dout;
    chk("tx_oe", 64'(cur_oe), 64'd1);
    h1 = 1'b1;
    wait_for("tx_hs2_low", 0, 1'b0, 400);
    h1 = 1'b0;
  endtask

  task automatic send_packet(input int cmd, input logic [7:0] addr, input logic [31:0] wd);
    logic [63:0] mask;
    mask = (64'd1 << bw) - 64'd1;
    send_word(16'(cmd));
    send_word({8'h00, addr});
    for (int i = 0; i < 32 / bw; i++) send_word(16'((64'(wd) >> (i * bw)) & mask));
  endtask

  task automatic run_txn(input int cmd, input logic [7:0] addr, input logic [31:0] wd,
                         input string tag);
    logic [63:0] rep, mask;
    logic [15:0] w;
    mask = (64'd1 << bw) - 64'd1;
    start_pulse();
    send_packet(cmd, addr, wd);
    rw = 1'b0;
    rep = exp_reply(cmd, bank_rd, bank_st, model_flag);
    for (int i = 0; i < 64 / bw; i++) begin
      recv_word(w);
      chk($sformatf("%s_word%0d", tag, i), 64'(w), (rep >> (i * bw)) & mask);
    end
    wait_for({tag, "_ack"}, 1, 1'b1, 400);
    rw = 1'b1;
    model_flag = 1'b0;
    chk({tag, "_flag_clear"}, 64'(cur_flag), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_hs2"}, 64'(cur_hs2), 64'd0);
    chk({tag, "_oe"}, 64'(cur_oe), 64'd0);
    chk({tag, "_ack"}, 64'(cur_ack), 64'd0);
    chk({tag, "_req"}, 64'(cur_req), 64'd0);
  endtask

  initial begin
    int n0, cmd;
    logic [31:0] wd;
    logic [7:0]  addr;
    logic [15:0] w;
    checks = 0; errors = 0; model_flag = 1'b0;
    reset = 1'b1; start = 1'b0; h1 = 1'b0; rw = 1'b1; data_in = '0;
    sel = 1'b0; bw = 8; bank_rd = '0; bank_st = '0;
    repeat (4) @(negedge clk);

    // reset state
    check_idle_outputs("reset");
    chk("reset_flag", 64'(cur_flag), 64'd0);
    chk("reset_dout", 64'(cur_dout), 64'd0);
    chk("reset_cmd", 64'(cur_cmd), 64'd0);
    chk("reset_addr", 64'(cur_addr), 64'd0);
    chk("reset_wdata", 64'(cur_wdata), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // write 0xDEADBEEF
    bank_rd = 32'hDEADBEEF; bank_st = 32'h0000_0001; n0 = cur_nreq;
    run_txn(1, 8'h10, 32'hDEADBEEF, "wr");
    chk("wr_nreq", 64'(cur_nreq), 64'(n0 + 1));
    chk("wr_cmd", 64'(cur_cap_cmd), 64'd1);
    chk("wr_addr", 64'(cur_cap_addr), 64'h10);
    chk("wr_wdata", 64'(cur_cap_wd), 64'hDEADBEEF);

    // read returning 100
    bank_rd = 32'd100; bank_st = $urandom; n0 = cur_nreq;
    run_txn(0, 8'h10, 32'h0, "rd");
    chk("rd_nreq", 64'(cur_nreq), 64'(n0 + 1));
    chk("rd_cmd", 64'(cur_cap_cmd), 64'd0);

    // bad command
    bank_rd = $urandom; bank_st = $urandom; n0 = cur_nreq;
    run_txn(7, 8'h10, $urandom, "bad");
    chk("bad_nreq", 64'(cur_nreq), 64'(n0));

    // randomized transactions
    for (int k = 0; k < 6; k++) begin
      case ($urandom_range(0, 2))
        0:       cmd = 0;
        1:       cmd = 1;
        default: cmd = int'($urandom_range(2, 255));
      endcase
      addr = 8'($urandom); wd = $urandom;
      bank_rd = $urandom; bank_st = $urandom; n0 = cur_nreq;
      run_txn(cmd, addr, wd, $sformatf("rnd%0d", k));
      if (cmd <= 1) begin
        chk("rnd_nreq", 64'(cur_nreq), 64'(n0 + 1));
        chk("rnd_addr", 64'(cur_cap_addr), 64'(addr));
        chk("rnd_wdata", 64'(cur_cap_wd), 64'(wd));
      end else begin
        chk("rnd_nreq_bad", 64'(cur_nreq), 64'(n0));
      end
    end

    // handshake timeout after 3 words
    n0 = cur_nreq;
    start_pulse();
    send_word(16'h0001); send_word(16'h0044); send_word(16'h0055);
    repeat (56) @(negedge clk);
    chk("to_not_early", 64'(cur_flag), 64'd0);
    wait_for("to_flag_set", 2, 1'b1, 16);
    check_idle_outputs("to");
    chk("to_nreq", 64'(cur_nreq), 64'(n0));
    repeat (5) @(negedge clk);
    chk("to_flag_sticky", 64'(cur_flag), 64'd1);
    model_flag = 1'b1;
    bank_rd = $urandom; bank_st = $urandom;
    run_txn(1, 8'h21, $urandom, "after_to");

    // restart on start after 2 words: only the second packet reaches the bank
    n0 = cur_nreq; wd = $urandom;
    bank_rd = $urandom; bank_st = $urandom;
    start_pulse();
    send_word(16'h0001); send_word(16'h0022);
    run_txn(1, 8'h33, wd, "abort");
    chk("abort_nreq", 64'(cur_nreq), 64'(n0 + 1));
    chk("abort_addr", 64'(cur_cap_addr), 64'h33);
    chk("abort_wdata", 64'(cur_cap_wd), 64'(wd));

    // 16-bit bus instance
    reset = 1'b1;
    repeat (2) @(negedge clk);
    sel = 1'b1; bw = 16; model_flag = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    bank_rd = 32'h12345678; bank_st = $urandom; n0 = cur_nreq;
    run_txn(1, 8'h5A, 32'h12345678, "w16");
    chk("w16_nreq", 64'(cur_nreq), 64'(n0 + 1));
    chk("w16_wdata", 64'(cur_cap_wd), 64'h12345678);
    chk("w16_addr", 64'(cur_cap_addr), 64'h5A);
    bank_rd = $urandom; bank_st = $urandom;
    run_txn(0, 8'h5A, 32'h0, "r16");

    // reset in the middle of the reply
    bank_rd = $urandom; bank_st = $urandom;
    start_pulse();
    send_packet(1, 8'h66, $urandom);
    rw = 1'b0;
    recv_word(w);
    wait_for("mid_tx_hs2", 0, 1'b1, 400);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_tx");
    chk("rst_tx_flag", 64'(cur_flag), 64'd0);
    chk("rst_tx_dout", 64'(cur_dout), 64'd0);
    chk("rst_tx_cmd", 64'(cur_cmd), 64'd0);
    chk("rst_tx_addr", 64'(cur_addr), 64'd0);
    chk("rst_tx_wdata", 64'(cur_wdata), 64'd0);
    rw = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);

    chk("oe_while_uP_drives", 64'(oe_viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
